// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and parameter defaults for the memory arbiter
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_WAIT   = 15;
    localparam int DEF_STARVE_LIM = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one peripheral bus between instruction fetch and load/store
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_WAIT   = DEF_MAX_WAIT,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                hold_o,
    output logic                err_o
);

    arb_state_e          r_state, w_next;
    logic [3:0]          r_starve;
    logic [7:0]          r_wait;
    logic                r_we, r_if_rvalid, r_ls_rvalid, r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_if_rdata, r_ls_rdata;
    logic [DATA_W/8-1:0] r_be;
    logic                w_starved, w_timeout, w_done;

    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_be    = r_be;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign err_o     = r_err;

    // state register; reset kills any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ARB_IDLE;
        else      r_state <= w_next;
    end

    // arbitration in IDLE, completion or timeout abort otherwise
    always_comb begin
        w_starved = (r_starve >= 4'(STARVE_LIM)) && if_req;
        w_timeout = (r_wait == 8'(MAX_WAIT - 1)) && !bus_ack;
        w_done    = (r_state != ARB_IDLE) && (bus_ack || w_timeout);
        w_next    = r_state;
        if (r_state == ARB_IDLE)
            w_next = (ls_req && !w_starved) ? ARB_DATA : (if_req ? ARB_FETCH : ARB_IDLE);
        else if (w_done)
            w_next = ARB_IDLE;
    end

    // grants pulse in the first bus cycle; hold is forced low while reset is asserted
    always_comb begin
        bus_req = r_state != ARB_IDLE;
        if_gnt  = (r_state == ARB_FETCH) && (r_wait == '0);
        ls_gnt  = (r_state == ARB_DATA) && (r_wait == '0);
        hold_o  = rst && (ls_req || r_state == ARB_DATA) && !r_ls_rvalid;
    end

    // wait/starvation counters and the bus register bank loaded at grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait   <= '0;
            r_starve <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '0;
        end else begin
            r_wait <= (r_state == ARB_IDLE || w_done) ? '0 : r_wait + 8'd1;
            if (r_state == ARB_IDLE && w_next == ARB_FETCH)
                r_starve <= '0;
            else if (r_state == ARB_IDLE && w_next == ARB_DATA && if_req && r_starve != 4'hF)
                r_starve <= r_starve + 4'd1;
            if (r_state == ARB_IDLE && w_next == ARB_DATA) begin
                r_addr  <= ls_addr;
                r_we    <= ls_we;
                r_wdata <= ls_wdata;
                r_be    <= ls_be;
            end else if (r_state == ARB_IDLE && w_next == ARB_FETCH) begin
                r_addr  <= if_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_be    <= '1;
            end
        end
    end

    // completion pulses and read data; stores and aborts return zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_done && r_state == ARB_FETCH;
            r_ls_rvalid <= w_done && r_state == ARB_DATA;
            r_err       <= w_done && !bus_ack;
            if (w_done && r_state == ARB_FETCH)
                r_if_rdata <= bus_ack ? bus_rdata : '0;
            if (w_done && r_state == ARB_DATA)
                r_ls_rdata <= (bus_ack && !r_we) ? bus_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int MW = 15;
    localparam int SL = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 0, rst = 0;
    logic        if_req = 0, if_gnt, if_rvalid;
    logic [31:0] if_addr = 0, if_rdata;
    logic        ls_req = 0, ls_we = 0, ls_gnt, ls_rvalid;
    logic [31:0] ls_addr = 0, ls_wdata = 0, ls_rdata;
    logic [3:0]  ls_be = 0, bus_be;
    logic        bus_req, bus_we, bus_ack = 0, hold_o, err_o;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;

    txn_t        fq[$], lq[$];
    txn_t        cur, mt;
    int          errors = 0, checks = 0;
    int          bidx = 0, sc = 0;
    bit          inflight = 0, p_if = 0, p_ls = 0, p_idle = 1;
    logic [31:0] last_if = 0, last_ls = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .STARVE_LIM(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .hold_o(hold_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory contents seen by the bus responder
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // address bits [5:2] encode how many wait cycles the responder inserts before ack
    function automatic int dly(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic logic exp_err(input txn_t t);
        return dly(t.addr) >= MW;
    endfunction

    function automatic logic [31:0] exp_rdata(input txn_t t);
        return (exp_err(t) || t.we) ? 32'h0 : mem_f(t.addr);
    endfunction

    function automatic int exp_cyc(input txn_t t);
        return exp_err(t) ? MW : dly(t.addr) + 1;
    endfunction

    function automatic logic [31:0] mk_addr(input int d);
        logic [31:0] a;
        a = $urandom();
        a[5:2] = 4'(d);
        a[1:0] = 2'b00;
        return a;
    endfunction

    function automatic int rand_d();
        return ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 15)) : int'($urandom_range(0, 3));
    endfunction

    task automatic issue_fetch(input int d);
        txn_t t;
        int   k;
        t = '{addr: mk_addr(d), we: 1'b0, wdata: 32'h0, be: 4'hF};
        if_req  = 1;
        if_addr = t.addr;
        fq.push_back(t);
        k = 0;
        @(negedge clk);
        while (!if_gnt && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!if_gnt) chk("if_gnt_timeout", 32'(k), 32'(0));
        @(posedge clk);
        #1 if_req = 0;
        if_addr = $urandom();
    endtask

    task automatic issue_ls(input int d);
        txn_t t;
        int   k;
        t = '{addr: mk_addr(d), we: 1'($urandom_range(0, 1)), wdata: $urandom(), be: 4'($urandom_range(0, 15))};
        ls_req   = 1;
        ls_we    = t.we;
        ls_addr  = t.addr;
        ls_wdata = t.wdata;
        ls_be    = t.be;
        lq.push_back(t);
        k = 0;
        @(negedge clk);
        while (!ls_gnt && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!ls_gnt) chk("ls_gnt_timeout", 32'(k), 32'(0));
        @(posedge clk);
        #1 ls_req = 0;
        ls_addr = $urandom();
        ls_wdata = $urandom();
    endtask

    task automatic drive_fetch(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 issue_fetch(rand_d());
        end
    endtask

    task automatic drive_ls(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            @(posedge clk);
            #1 issue_ls(rand_d());
        end
    endtask

    // monitor, scoreboard and bus responder, all sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            bidx = 0; sc = 0; inflight = 0;
            p_if = 0; p_ls = 0; p_idle = 1;
            last_if = 0; last_ls = 0;
            bus_ack = 0; bus_rdata = 0;
        end else begin
            if (if_rvalid) begin
                if (fq.size() == 0) chk("if_rvalid_unexpected", 32'(1), 32'(0));
                else begin
                    mt = fq.pop_front();
                    last_if = exp_rdata(mt);
                    chk("if_rdata", if_rdata, last_if);
                    chk("if_err", 32'(err_o), 32'(exp_err(mt)));
                    chk("if_bus_cycles", 32'(bidx), 32'(exp_cyc(mt)));
                end
            end else chk("if_rdata_hold", if_rdata, last_if);
            if (ls_rvalid) begin
                if (lq.size() == 0) chk("ls_rvalid_unexpected", 32'(1), 32'(0));
                else begin
                    mt = lq.pop_front();
                    last_ls = exp_rdata(mt);
                    chk("ls_rdata", ls_rdata, last_ls);
                    chk("ls_err", 32'(err_o), 32'(exp_err(mt)));
                    chk("ls_bus_cycles", 32'(bidx), 32'(exp_cyc(mt)));
                end
            end else chk("ls_rdata_hold", ls_rdata, last_ls);
            if (!if_rvalid && !ls_rvalid) chk("err_spurious", 32'(err_o), 32'(0));
            chk("hold_o", 32'(hold_o), 32'((ls_req | inflight | ls_gnt) & ~ls_rvalid));
            if (ls_rvalid) inflight = 0;
            chk("gnt_timing", 32'(if_gnt | ls_gnt), 32'(p_idle & (p_if | p_ls)));
            if (if_gnt || ls_gnt) begin
                chk("gnt_winner", 32'(ls_gnt), 32'(p_ls && !(p_if && sc >= SL)));
                if (ls_gnt) begin
                    if (p_if && sc < 15) sc++;
                    inflight = 1;
                    cur = (lq.size() != 0) ? lq[0] : '0;
                    chk("gnt_bus_wdata", bus_wdata, cur.wdata);
                end else begin
                    sc = 0;
                    cur = (fq.size() != 0) ? fq[0] : '0;
                end
                bidx = 0;
                chk("gnt_bus_addr", bus_addr, cur.addr);
                chk("gnt_bus_we", 32'(bus_we), 32'(cur.we));
                chk("gnt_bus_be", 32'(bus_be), 32'(cur.be));
            end else if (bus_req) begin
                chk("bus_addr_stable", bus_addr, cur.addr);
                chk("bus_we_stable", 32'(bus_we), 32'(cur.we));
                chk("bus_be_stable", 32'(bus_be), 32'(cur.be));
                if (cur.we) chk("bus_wdata_stable", bus_wdata, cur.wdata);
            end
            if (bus_req) begin
                bus_ack = (bidx == dly(cur.addr));
                bus_rdata = bus_ack ? mem_f(cur.addr) : $urandom();
                bidx++;
            end else begin
                bus_ack = ($urandom_range(0, 3) == 0);
                bus_rdata = $urandom();
            end
            p_if = if_req;
            p_ls = ls_req;
            p_idle = !bus_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        ls_req = 1;
        #2;
        chk("rst_bus_req", 32'(bus_req), 32'(0));
        chk("rst_hold_o", 32'(hold_o), 32'(0));
        chk("rst_if_gnt", 32'(if_gnt), 32'(0));
        chk("rst_ls_gnt", 32'(ls_gnt), 32'(0));
        chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_rdata", if_rdata | ls_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        ls_req = 0;
        fork
            drive_fetch(60);
            drive_ls(80);
        join
        for (int k = 0; k < 200 && (fq.size() != 0 || lq.size() != 0); k++) @(negedge clk);
        chk("drain", 32'(fq.size() + lq.size()), 32'(0));
        @(posedge clk);
        #1;
        fork
            issue_fetch(15);
            begin
                @(posedge if_gnt);
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                #2 rst = 0;
                #1;
                chk("midrst_bus_req", 32'(bus_req), 32'(0));
                chk("midrst_hold_o", 32'(hold_o), 32'(0));
                chk("midrst_gnt", 32'({if_gnt, ls_gnt}), 32'(0));
                chk("midrst_rvalid", 32'({if_rvalid, ls_rvalid, err_o}), 32'(0));
                chk("midrst_bus_addr", bus_addr, 32'h0);
            end
        join
        fq.delete();
        @(negedge clk);
        chk("midrst_bus_req_held", 32'(bus_req), 32'(0));
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 issue_fetch(1);
        for (int k = 0; k < 50 && fq.size() != 0; k++) @(negedge clk);
        chk("post_rst_fetch_done", 32'(fq.size()), 32'(0));
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
